ts_trigger_cond: RTL and testbench
==================================

Name: ts_trigger_cond

Overview:
- Conditioning front-end that feeds the AXI trigger subsystem's external-trigger inputs.
- Takes N_CH asynchronous trigger pins and performs, per channel:
  - synchronisation;
  - glitch filtering;
  - rising/falling edge selection.
- Outputs single-cycle qualified trigger pulses.
- Captures an RTC timestamp plus source mask for each trigger cycle into a one-deep valid/ready event register.

Parameters:
- N_CH, 8, number of trigger channels.
- FILT_WIDTH, 8, width of glitch-filter length and per-channel filter counters.

Ports:
- aclk  in  1  system clock; all logic in this domain.
- aresetn  in  1  reset, synchronous, active-low.
- trig_in  in  N_CH  asynchronous trigger pins.
- cfg_rise_en  in  N_CH  per-channel rising-edge qualify enable.
- cfg_fall_en  in  N_CH  per-channel falling-edge qualify enable.
- cfg_filt_len  in  FILT_WIDTH  glitch-filter length L (quasi-static).
- cfg_holdoff  in  16  holdoff length H in cycles (used only with TS_TRIG_HOLDOFF_EN).
- rtc_sec  in  32  RTC seconds, aclk domain.
- rtc_nsec  in  32  RTC nanoseconds, aclk domain.
- trig_out  out  N_CH  qualified trigger pulses, one cycle each; drives trigger subsystem ext_trigger.
- ev_valid  out  1  event register holds an event.
- ev_ready  in  1  consumer accepts event.
- ev_src  out  N_CH  trig_out mask of captured event.
- ev_sec  out  32  timestamp seconds.
- ev_nsec  out  32  timestamp nanoseconds.
- ev_overflow  out  1  sticky: an event was dropped.
- ev_overflow_clr  in  1  one-cycle clear of ev_overflow.

Behaviour:
- Reset: aresetn low at an aclk edge forces the following to 0:
  - sync stages, filt, filter counters, holdoff counters;
  - trig_out, ev_valid, ev_src, ev_sec, ev_nsec, ev_overflow.
  - FSM enters INIT, arm counter = 0.
  - Reset mid-operation discards any pending event and overflow flag.
- Sync: 2-FF synchroniser per channel (s1, s2); no logic between s1 and s2.
- FSM:
  - INIT: for 2 edges after reset release (sync fill) nothing changes.
  - INIT → LOAD on the 3rd edge.
  - LOAD: filt <= s2 for all channels; counters = 0; no trig_out.
  - LOAD → RUN next edge.
  - RUN: normal operation, exited only by reset.
  - Effect: a level already present at reset release never produces a trigger.
- Filter (RUN, per channel):
  - If s2 == filt, cnt <= 0.
  - Else if cnt >= L, then filt <= s2 and cnt <= 0 ("update").
  - Else cnt <= cnt + 1.
  - ">=" makes a mid-count reduction of cfg_filt_len take effect immediately.
  - Pulses shorter than L+1 cycles at s2 are rejected.
  - No counter wrap: cnt saturates at its compare point.
- Qualify:
  - trig_out[i] <= update_i & ((s2_i & cfg_rise_en[i]) | (~s2_i & cfg_fall_en[i])), same edge as filt update.
  - trig_out is 0 in every other cycle.
  - Latency: if edge k is the first to sample the new level into s1 and the level is held, trig_out is high in the cycle after edge k+2+L.
- Event capture, at an edge where trig_out next value nonzero:
  - If ev_valid == 0, or (ev_valid & ev_ready): load ev_src <= trig_out next, ev_sec/ev_nsec <= rtc_sec/rtc_nsec at that edge, ev_valid <= 1.
    - ev_valid rises in the same cycle as trig_out.
  - Otherwise: event dropped, ev_overflow <= 1; the held event is unchanged.
  - Simultaneous events on several channels share one event (multi-bit ev_src).
- Event handshake:
  - ev_valid & ev_ready with no new event: ev_valid <= 0.
  - Outputs stable while ev_valid & ~ev_ready.
- Overflow:
  - ev_overflow_clr clears the flag.
  - Simultaneous set and clear: set wins.

Optional Feature:
- Macro: TS_TRIG_HOLDOFF_EN.
- Defined:
  - Per-channel 16-bit holdoff counter loads H on each trig_out[i] assertion.
  - While the counter is nonzero, trig_out[i] is suppressed and the counter decrements once per cycle.
  - Filter state still tracks the input.
  - H = 0 disables holdoff.
  - Reset clears the counters.
- Undefined:
  - cfg_holdoff is ignored and no holdoff logic is generated.
  - Behaviour is otherwise identical.

Test Plan:
- Reset release with trig_in=8'hFF held high, L=0, rise/fall en=FF: no trig_out, ev_valid=0 for 100 cycles after release.
- Ch0 rising edge, L=3, rise_en[0]=1, edge sampled at edge k, ev_ready=1: trig_out=8'h01 for exactly one cycle after edge k+5; ev_src=01 with rtc values latched at that edge.
- Ch2 glitch high for 3 cycles, L=3: no trig_out. Same pulse held 4 cycles: one trig_out[2] pulse. With fall_en[2]=1: a second pulse after release.
- Ch1 and ch5 rise in the same sampling edge: single event with ev_src=8'h22, one ev_valid.
- ev_ready=0, two separate triggers: first event held unchanged, ev_overflow=1. ev_overflow_clr coincident with a third dropped trigger: ev_overflow stays 1.
- TS_TRIG_HOLDOFF_EN, H=10, L=0, ch3 toggles every 2 cycles (rise+fall en): pulses at least 11 cycles apart. H=0: a pulse every transition.

Source files
------------

// File: rtl/ts_trigger_cond_if.sv
// Event-side bundle of ts_trigger_cond: one-deep valid/ready timestamped event
// register plus sticky overflow flag and its clear.
interface ts_trigger_cond_if #(
    parameter int unsigned N_CH = 8
);
    logic            ev_valid;
    logic            ev_ready;
    logic [N_CH-1:0] ev_src;
    logic [31:0]     ev_sec;
    logic [31:0]     ev_nsec;
    logic            ev_overflow;
    logic            ev_overflow_clr;

    modport master (
        output ev_valid, ev_src, ev_sec, ev_nsec, ev_overflow,
        input  ev_ready, ev_overflow_clr
    );

    modport slave (
        input  ev_valid, ev_src, ev_sec, ev_nsec, ev_overflow,
        output ev_ready, ev_overflow_clr
    );
endinterface

// File: rtl/ts_trigger_cond.sv
// Trigger-pin conditioning: sync, glitch filter, edge qualify, timestamped event capture.
// Optional per-channel retrigger holdoff is built only when TS_TRIG_HOLDOFF_EN is defined.
module ts_trigger_cond #(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned FILT_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [N_CH-1:0]       trig_in,
    input  logic [N_CH-1:0]       cfg_rise_en,
    input  logic [N_CH-1:0]       cfg_fall_en,
    input  logic [FILT_WIDTH-1:0] cfg_filt_len,
    input  logic [15:0]           cfg_holdoff,
    input  logic [31:0]           rtc_sec,
    input  logic [31:0]           rtc_nsec,
    output logic [N_CH-1:0]       trig_out,
    ts_trigger_cond_if.master     ev
);

    typedef enum logic [1:0] {StInit, StLoad, StRun} state_e;

    state_e                state_q, state_d;
    logic [1:0]            arm_q, arm_d;
    logic [N_CH-1:0]       s1_q, s2_q;
    logic [N_CH-1:0]       filt_q, filt_d;
    logic [FILT_WIDTH-1:0] cnt_q [N_CH];
    logic [FILT_WIDTH-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]       update, qual;
    logic [N_CH-1:0]       trig_q, trig_d;

    logic                  ev_valid_q, ev_valid_d;
    logic [N_CH-1:0]       ev_src_q, ev_src_d;
    logic [31:0]           ev_sec_q, ev_sec_d;
    logic [31:0]           ev_nsec_q, ev_nsec_d;
    logic                  ev_ovf_q, ev_ovf_d;

    // Hold off filter loading until the synchroniser holds real pin levels.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        unique case (state_q)
            StInit: begin
                if (arm_q == 2'd2) state_d = StLoad;
                else               arm_d   = arm_q + 2'd1;
            end
            StLoad:  state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        filt_d = filt_q;
        update = '0;
        for (int i = 0; i < N_CH; i++) cnt_d[i] = cnt_q[i];
        if (state_q == StLoad) begin
            filt_d = s2_q;
            for (int i = 0; i < N_CH; i++) cnt_d[i] = '0;
        end else if (state_q == StRun) begin
            for (int i = 0; i < N_CH; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= cfg_filt_len) begin
                    filt_d[i] = s2_q[i];
                    cnt_d[i]  = '0;
                    update[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + FILT_WIDTH'(1);
                end
            end
        end
        qual = update & ((s2_q & cfg_rise_en) | (~s2_q & cfg_fall_en));
    end

`ifdef TS_TRIG_HOLDOFF_EN
    logic [15:0] hold_q [N_CH];
    logic [15:0] hold_d [N_CH];

    always_comb begin
        trig_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i] = hold_q[i];
            if (hold_q[i] != 16'd0) begin
                hold_d[i] = hold_q[i] - 16'd1;
            end else if (qual[i]) begin
                trig_d[i] = 1'b1;
                hold_d[i] = cfg_holdoff;
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!aresetn) hold_q[i] <= '0;
            else          hold_q[i] <= hold_d[i];
        end
    end
`else
    logic unused_holdoff;
    assign unused_holdoff = ^cfg_holdoff;
    assign trig_d         = qual;
`endif

    // A new event may replace the held one in the same cycle it is consumed.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_src_d   = ev_src_q;
        ev_sec_d   = ev_sec_q;
        ev_nsec_d  = ev_nsec_q;
        ev_ovf_d   = ev_ovf_q;
        if (ev.ev_overflow_clr) ev_ovf_d = 1'b0;
        if (|trig_d) begin
            if (!ev_valid_q || ev.ev_ready) begin
                ev_valid_d = 1'b1;
                ev_src_d   = trig_d;
                ev_sec_d   = rtc_sec;
                ev_nsec_d  = rtc_nsec;
            end else begin
                ev_ovf_d = 1'b1;
            end
        end else if (ev_valid_q && ev.ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= StInit;
            arm_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            filt_q     <= '0;
            trig_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_src_q   <= '0;
            ev_sec_q   <= '0;
            ev_nsec_q  <= '0;
            ev_ovf_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            s1_q       <= trig_in;
            s2_q       <= s1_q;
            filt_q     <= filt_d;
            trig_q     <= trig_d;
            ev_valid_q <= ev_valid_d;
            ev_src_q   <= ev_src_d;
            ev_sec_q   <= ev_sec_d;
            ev_nsec_q  <= ev_nsec_d;
            ev_ovf_q   <= ev_ovf_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign trig_out       = trig_q;
    assign ev.ev_valid    = ev_valid_q;
    assign ev.ev_src      = ev_src_q;
    assign ev.ev_sec      = ev_sec_q;
    assign ev.ev_nsec     = ev_nsec_q;
    assign ev.ev_overflow = ev_ovf_q;

endmodule

// File: tb/tb_ts_trigger_cond.sv
// Bench for ts_trigger_cond: directed scenarios plus randomised traffic, each cycle
// checked against a behavioural model of pin history, debounce and event slot.
module tb_ts_trigger_cond;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  trig_in;
    logic [7:0]  cfg_rise_en;
    logic [7:0]  cfg_fall_en;
    logic [7:0]  cfg_filt_len;
    logic [15:0] cfg_holdoff;
    logic [31:0] rtc_sec;
    logic [31:0] rtc_nsec;
    logic [7:0]  trig_out;

    int vectors    = 0;
    int miscompares = 0;

    ts_trigger_cond_if #(.N_CH(8)) ev_if ();

    ts_trigger_cond #(.N_CH(8), .FILT_WIDTH(8)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .trig_in      (trig_in),
        .cfg_rise_en  (cfg_rise_en),
        .cfg_fall_en  (cfg_fall_en),
        .cfg_filt_len (cfg_filt_len),
        .cfg_holdoff  (cfg_holdoff),
        .rtc_sec      (rtc_sec),
        .rtc_nsec     (rtc_nsec),
        .trig_out     (trig_out),
        .ev           (ev_if)
    );

    always #5 aclk = ~aclk;

    // Reference model: pin history, debounced level, consecutive-disagreement run.
    int          m_age;
    logic [7:0]  m_s1, m_s2, m_filt, m_trig;
    int          m_diff [8];
    int          m_hold [8];
    logic        m_v, m_ovf;
    logic [7:0]  m_src;
    logic [31:0] m_sec, m_nsec;

    task automatic model_step();
        logic [7:0] fire;
        logic       drop;
        if (!aresetn) begin
            m_age = 0; m_s1 = '0; m_s2 = '0; m_filt = '0; m_trig = '0;
            m_v = 1'b0; m_ovf = 1'b0; m_src = '0; m_sec = '0; m_nsec = '0;
            for (int c = 0; c < 8; c++) begin m_diff[c] = 0; m_hold[c] = 0; end
            return;
        end
        if (m_age < 10) m_age++;
        fire = '0;
        if (m_age == 4) begin
            m_filt = m_s2;
            for (int c = 0; c < 8; c++) m_diff[c] = 0;
        end else if (m_age >= 5) begin
            for (int c = 0; c < 8; c++) begin
                if (m_s2[c] !== m_filt[c]) begin
                    m_diff[c]++;
                    if (m_diff[c] > int'(cfg_filt_len)) begin
                        m_filt[c] = m_s2[c];
                        m_diff[c] = 0;
                        fire[c]   = m_s2[c] ? cfg_rise_en[c] : cfg_fall_en[c];
                    end
                end else begin
                    m_diff[c] = 0;
                end
            end
        end
`ifdef TS_TRIG_HOLDOFF_EN
        for (int c = 0; c < 8; c++) begin
            if (m_hold[c] > 0) begin
                m_hold[c]--;
                fire[c] = 1'b0;
            end else if (fire[c]) begin
                m_hold[c] = int'(cfg_holdoff);
            end
        end
`endif
        m_trig = fire;
        drop   = 1'b0;
        if (fire != 0) begin
            if (!m_v || ev_if.ev_ready) begin
                m_v = 1'b1; m_src = fire; m_sec = rtc_sec; m_nsec = rtc_nsec;
            end else begin
                drop = 1'b1;
            end
        end else if (m_v && ev_if.ev_ready) begin
            m_v = 1'b0;
        end
        if (drop)                        m_ovf = 1'b1;
        else if (ev_if.ev_overflow_clr)  m_ovf = 1'b0;
        m_s2 = m_s1;
        m_s1 = trig_in;
    endtask

    task automatic cycle();
        rtc_sec  = rtc_sec + 32'd1;
        rtc_nsec = $urandom;
        @(posedge aclk);
        model_step();
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        cycle();
        cycle();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        trig_in = 8'hFF; cfg_filt_len = 8'd0; cfg_rise_en = 8'hFF; cfg_fall_en = 8'hFF;
        aresetn = 1'b0;
        cycle();
        vectors++;
        if ({trig_out, ev_if.ev_valid, ev_if.ev_src, ev_if.ev_sec, ev_if.ev_nsec,
             ev_if.ev_overflow} !== 82'd0) begin
            miscompares++;
            $display("FAIL reset_state: trig=%h v=%b src=%h sec=%h nsec=%h ovf=%b, want all 0",
                     trig_out, ev_if.ev_valid, ev_if.ev_src, ev_if.ev_sec, ev_if.ev_nsec,
                     ev_if.ev_overflow);
        end
        cycle();
        aresetn = 1'b1;
        for (int j = 0; j < 100; j++) begin
            cycle();
            vectors++;
            if (trig_out !== 8'h00 || ev_if.ev_valid !== 1'b0 ||
                {trig_out, ev_if.ev_valid, ev_if.ev_src, ev_if.ev_sec, ev_if.ev_nsec,
                 ev_if.ev_overflow} !== {m_trig, m_v, m_src, m_sec, m_nsec, m_ovf}) begin
                miscompares++;
                $display("FAIL level_at_release cyc %0d: trig=%h v=%b, want trig=00 v=0",
                         j, trig_out, ev_if.ev_valid);
            end
        end
    endtask

    task automatic test_rise_latency();
        trig_in = 8'h00; cfg_filt_len = 8'd3; cfg_rise_en = 8'h01; cfg_fall_en = 8'h00;
        ev_if.ev_ready = 1'b1;
        do_reset();
        for (int j = 0; j < 10; j++) cycle();
        trig_in = 8'h01;
        for (int j = 1; j <= 10; j++) begin
            cycle();
            vectors++;
            if (trig_out !== ((j == 6) ? 8'h01 : 8'h00) ||
                (j == 6 && (ev_if.ev_valid !== 1'b1 || ev_if.ev_src !== 8'h01 ||
                            ev_if.ev_sec !== rtc_sec || ev_if.ev_nsec !== rtc_nsec))) begin
                miscompares++;
                $display("FAIL rise_latency edge k+%0d: trig=%h v=%b src=%h sec=%h, want trig=%h",
                         j - 1, trig_out, ev_if.ev_valid, ev_if.ev_src, ev_if.ev_sec,
                         (j == 6) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_glitch();
        int pulses;
        int want [3] = '{0, 1, 2};
        int width [3] = '{3, 4, 4};
        trig_in = 8'h00; cfg_filt_len = 8'd3; cfg_rise_en = 8'h04; cfg_fall_en = 8'h00;
        ev_if.ev_ready = 1'b1;
        do_reset();
        for (int j = 0; j < 10; j++) cycle();
        for (int p = 0; p < 3; p++) begin
            if (p == 2) cfg_fall_en = 8'h04;
            pulses = 0;
            trig_in = 8'h04;
            for (int j = 0; j < width[p]; j++) begin
                cycle();
                if (trig_out[2] === 1'b1) pulses++;
            end
            trig_in = 8'h00;
            for (int j = 0; j < 12; j++) begin
                cycle();
                if (trig_out[2] === 1'b1) pulses++;
            end
            vectors++;
            if (pulses != want[p]) begin
                miscompares++;
                $display("FAIL glitch pulse %0d (width %0d): got %0d pulses, want %0d",
                         p, width[p], pulses, want[p]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int ev_cycles;
        int trig_cycles;
        trig_in = 8'h00; cfg_filt_len = 8'd2; cfg_rise_en = 8'hFF; cfg_fall_en = 8'h00;
        ev_if.ev_ready = 1'b1;
        do_reset();
        for (int j = 0; j < 10; j++) cycle();
        trig_in = 8'h22;
        ev_cycles = 0;
        trig_cycles = 0;
        for (int j = 0; j < 12; j++) begin
            cycle();
            if (ev_if.ev_valid === 1'b1) begin
                ev_cycles++;
                vectors++;
                if (ev_if.ev_src !== 8'h22 || trig_out !== 8'h22) begin
                    miscompares++;
                    $display("FAIL simultaneous src: src=%h trig=%h, want 22/22",
                             ev_if.ev_src, trig_out);
                end
            end
            if (trig_out !== 8'h00) trig_cycles++;
        end
        vectors++;
        if (ev_cycles != 1 || trig_cycles != 1) begin
            miscompares++;
            $display("FAIL simultaneous count: ev_valid cycles %0d trig cycles %0d, want 1/1",
                     ev_cycles, trig_cycles);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] first_sec;
        trig_in = 8'h00; cfg_filt_len = 8'd0; cfg_rise_en = 8'h01; cfg_fall_en = 8'h00;
        ev_if.ev_ready = 1'b0;
        do_reset();
        for (int j = 0; j < 10; j++) cycle();
        trig_in = 8'h01;
        cycle(); cycle(); cycle();
        first_sec = rtc_sec;
        vectors++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_src !== 8'h01 || ev_if.ev_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_first: v=%b src=%h ovf=%b, want 1/01/0",
                     ev_if.ev_valid, ev_if.ev_src, ev_if.ev_overflow);
        end
        trig_in = 8'h00;
        for (int j = 0; j < 4; j++) cycle();
        trig_in = 8'h01;
        for (int j = 0; j < 4; j++) cycle();
        vectors++;
        if (ev_if.ev_overflow !== 1'b1 || ev_if.ev_sec !== first_sec || ev_if.ev_src !== 8'h01) begin
            miscompares++;
            $display("FAIL ovf_drop: ovf=%b sec=%h src=%h, want 1/%h/01",
                     ev_if.ev_overflow, ev_if.ev_sec, ev_if.ev_src, first_sec);
        end
        trig_in = 8'h00;
        for (int j = 0; j < 4; j++) cycle();
        trig_in = 8'h01;
        cycle(); cycle();
        ev_if.ev_overflow_clr = 1'b1;
        cycle();
        ev_if.ev_overflow_clr = 1'b0;
        vectors++;
        if (trig_out !== 8'h01 || ev_if.ev_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: trig=%h ovf=%b, want 01/1", trig_out, ev_if.ev_overflow);
        end
        ev_if.ev_overflow_clr = 1'b1;
        cycle();
        ev_if.ev_overflow_clr = 1'b0;
        vectors++;
        if (ev_if.ev_overflow !== 1'b0 || ev_if.ev_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b v=%b, want 0/1", ev_if.ev_overflow, ev_if.ev_valid);
        end
        ev_if.ev_ready = 1'b1;
        cycle();
        vectors++;
        if (ev_if.ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ev_consume: v=%b, want 0", ev_if.ev_valid);
        end
    endtask

`ifdef TS_TRIG_HOLDOFF_EN
    task automatic test_holdoff();
        int last, min_gap, pulses;
        trig_in = 8'h00; cfg_filt_len = 8'd0; cfg_rise_en = 8'h08; cfg_fall_en = 8'h08;
        ev_if.ev_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            cfg_holdoff = (pass == 0) ? 16'd10 : 16'd0;
            do_reset();
            for (int j = 0; j < 10; j++) cycle();
            last = -1000; min_gap = 1000; pulses = 0;
            for (int j = 0; j < 60; j++) begin
                if (j % 2 == 0 && j < 40) trig_in = trig_in ^ 8'h08;
                cycle();
                if (trig_out[3] === 1'b1) begin
                    pulses++;
                    if (j - last < min_gap) min_gap = j - last;
                    last = j;
                end
            end
            vectors++;
            if ((pass == 0 && (min_gap < 11 || pulses == 0)) || (pass == 1 && pulses != 20)) begin
                miscompares++;
                $display("FAIL holdoff H=%0d: pulses %0d min gap %0d", cfg_holdoff, pulses, min_gap);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int seg = 0; seg < 12; seg++) begin
            cfg_filt_len = 8'($urandom_range(0, 4));
            cfg_rise_en  = 8'($urandom);
            cfg_fall_en  = 8'($urandom);
            cfg_holdoff  = 16'($urandom_range(0, 6));
            for (int j = 0; j < 200; j++) begin
                aresetn = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 3) == 0) trig_in = trig_in ^ (8'd1 << $urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) trig_in = 8'($urandom);
                ev_if.ev_ready        = ($urandom_range(0, 3) != 0);
                ev_if.ev_overflow_clr = ($urandom_range(0, 7) == 0);
                cycle();
                vectors++;
                if ({trig_out, ev_if.ev_valid, ev_if.ev_src, ev_if.ev_sec, ev_if.ev_nsec,
                     ev_if.ev_overflow} !== {m_trig, m_v, m_src, m_sec, m_nsec, m_ovf}) begin
                    miscompares++;
                    $display("FAIL random seg %0d cyc %0d: got trig=%h v=%b src=%h sec=%h nsec=%h ovf=%b, want trig=%h v=%b src=%h sec=%h nsec=%h ovf=%b",
                             seg, j, trig_out, ev_if.ev_valid, ev_if.ev_src, ev_if.ev_sec,
                             ev_if.ev_nsec, ev_if.ev_overflow, m_trig, m_v, m_src, m_sec,
                             m_nsec, m_ovf);
                end
            end
        end
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0; trig_in = '0; cfg_rise_en = '0; cfg_fall_en = '0;
        cfg_filt_len = '0; cfg_holdoff = '0; rtc_sec = '0; rtc_nsec = '0;
        ev_if.ev_ready = 1'b0; ev_if.ev_overflow_clr = 1'b0;
        @(negedge aclk);
        test_reset();
        test_rise_latency();
        test_glitch();
        test_simultaneous();
        test_overflow();
`ifdef TS_TRIG_HOLDOFF_EN
        test_holdoff();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
